nn_weight_loader: RTL and testbench

NN_WEIGHT_LOADER -- requirements
Module: nn_weight_loader

---
 rtl/nn_weight_loader.sv | 132 +++++++++++++
 tb/tb_nn_weight_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nn_weight_loader.sv
// nn_weight_loader: streams a fixed-length load of weight words from a
// valid/ready host port into a downstream network's shift chain. Each
// accepted word appears on weights_o with a one-cycle shift_o strobe on the
// following cycle. A load ends with a one-cycle done_o pulse after
// NumWeights words, or silently on abort_i.
// Optional feature: define NN_WL_CHECKSUM_EN to add checksum_o, which is the
// running modulo-2^DataWidth sum of the words accepted in the current load.
module nn_weight_loader #(
   parameter int DataWidth  = 32,
   parameter int NumWeights = 24,
   localparam int CountWidth = $clog2(NumWeights + 1)
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [DataWidth-1:0]  wdata_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   output logic [DataWidth-1:0]  weights_o,
   output logic                  shift_o,
   output logic [CountWidth-1:0] count_o,
   output logic                  busy_o,
   output logic                  done_o
`ifdef NN_WL_CHECKSUM_EN
   ,
   output logic [DataWidth-1:0]  checksum_o
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Count value held just before the final word of a load is accepted.
   localparam logic [CountWidth-1:0] LastCount = CountWidth'(NumWeights - 1);

   state_t                  state_q, state_d;
   logic [CountWidth-1:0]   count_q, count_d;
   logic [DataWidth-1:0]    weights_q, weights_d;
   logic                    shift_q, shift_d;
   logic                    xfer;
   logic                    load_start;

   // A word is taken only in LOAD; an abort in the same cycle discards it.
   assign xfer       = (state_q == ST_LOAD) && wvalid_i && !abort_i;
   assign load_start = (state_q == ST_IDLE) && start_i;

   // Next-state and datapath updates; the strobe defaults low every cycle.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      weights_d = weights_q;
      shift_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               state_d = ST_LOAD;
               count_d = '0;
            end
         end
         ST_LOAD: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (xfer) begin
               weights_d = wdata_i;
               shift_d   = 1'b1;
               count_d   = count_q + CountWidth'(1);
               if (count_q == LastCount) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         weights_q <= '0;
         shift_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         weights_q <= weights_d;
         shift_q   <= shift_d;
      end
   end

   assign wready_o  = (state_q == ST_LOAD);
   assign busy_o    = (state_q == ST_LOAD);
   assign done_o    = (state_q == ST_DONE);
   assign weights_o = weights_q;
   assign shift_o   = shift_q;
   assign count_o   = count_q;

`ifdef NN_WL_CHECKSUM_EN
   logic [DataWidth-1:0] checksum_q, checksum_d;

   // Running sum: cleared when a load starts, accumulated on each accepted word.
   always_comb begin
      checksum_d = checksum_q;
      if (load_start) begin
         checksum_d = '0;
      end else if (xfer) begin
         checksum_d = checksum_q + wdata_i;
      end
   end

   // Checksum register, cleared by reset.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_nn_weight_loader.sv
// Testbench for nn_weight_loader (NumWeights=4): directed scenarios followed by
// randomized traffic, checked against a behavioural model of the load protocol.
module tb_nn_weight_loader;
   localparam int DW = 32;
   localparam int NW = 4;
   localparam int CW = $clog2(NW + 1);

   logic          clk_i = 1'b0;
   logic          reset_ni, start_i, abort_i, wvalid_i;
   logic [DW-1:0] wdata_i;
   logic          wready_o, shift_o, busy_o, done_o;
   logic [DW-1:0] weights_o;
   logic [CW-1:0] count_o;
`ifdef NN_WL_CHECKSUM_EN
   logic [DW-1:0] checksum_o;
`endif

   nn_weight_loader #(.DataWidth(DW), .NumWeights(NW)) dut (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .start_i   (start_i),
      .abort_i   (abort_i),
      .wdata_i   (wdata_i),
      .wvalid_i  (wvalid_i),
      .wready_o  (wready_o),
      .weights_o (weights_o),
      .shift_o   (shift_o),
      .count_o   (count_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
`ifdef NN_WL_CHECKSUM_EN
      ,
      .checksum_o(checksum_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Behavioural model: phase of the load protocol and the observable results.
   typedef enum int {M_IDLE, M_LOAD, M_DONE} mphase_t;
   mphase_t        m_phase = M_IDLE;
   bit             m_known = 1'b0;
   int unsigned    m_count = 0;
   logic [DW-1:0]  m_weights = '0;
   bit             m_shift = 1'b0;
   logic [DW-1:0]  m_sum = '0;
   logic [DW-1:0]  sent_q[$];
   logic [DW-1:0]  got_q[$];
   int             loads_done = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, check ready, clock, update model, check outputs.
   task automatic cycle(input logic rn, input logic st, input logic ab,
                        input logic vld, input logic [DW-1:0] d);
      reset_ni = rn; start_i = st; abort_i = ab; wvalid_i = vld; wdata_i = d;
      #1;
      if (m_known) chk("wready", DW'(wready_o), DW'(m_phase == M_LOAD));
      @(posedge clk_i);
      m_shift = 1'b0;
      if (!rn) begin
         m_phase = M_IDLE; m_count = 0; m_weights = '0; m_sum = '0;
         sent_q.delete(); got_q.delete();
         m_known = 1'b1;
      end else begin
         case (m_phase)
            M_IDLE: if (st) begin
               m_phase = M_LOAD; m_count = 0; m_sum = '0;
               sent_q.delete(); got_q.delete();
            end
            M_LOAD: begin
               if (ab) m_phase = M_IDLE;
               else if (vld) begin
                  m_weights = d; m_shift = 1'b1; m_count++;
                  m_sum = m_sum + d;
                  sent_q.push_back(d);
                  if (m_count == NW) m_phase = M_DONE;
               end
            end
            default: m_phase = M_IDLE;
         endcase
      end
      #1;
      chk("shift",   DW'(shift_o),  DW'(m_shift));
      chk("weights", weights_o,     m_weights);
      chk("count",   DW'(count_o),  DW'(m_count));
      chk("busy",    DW'(busy_o),   DW'(m_phase == M_LOAD));
      chk("done",    DW'(done_o),   DW'(m_phase == M_DONE));
`ifdef NN_WL_CHECKSUM_EN
      chk("checksum", checksum_o, m_sum);
`endif
      if (shift_o === 1'b1) got_q.push_back(weights_o);
      if (m_phase == M_DONE) begin
         loads_done++;
         chk("strobes_per_load", DW'(got_q.size()), DW'(NW));
         for (int i = 0; i < NW && i < got_q.size(); i++)
            chk("chain_word", got_q[i], sent_q[i]);
      end
      $display("cyc rn=%0b st=%0b ab=%0b v=%0b d=%h | shift=%0b w=%h cnt=%0d busy=%0b done=%0b",
               rn, st, ab, vld, d, shift_o, weights_o, count_o, busy_o, done_o);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
   endtask

   logic [DW-1:0] words[4];

   initial begin
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
      reset_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; wvalid_i = 1'b0; wdata_i = '0;

      // Reset state
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD);
      idle(1);

      // Back-to-back full load
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, words[i]);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h99);  // DONE: word ignored
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h98);  // IDLE: word ignored
      chk("loads_after_first", DW'(loads_done), DW'(1));

      // Valid every other cycle
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b1, words[i]);
         cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hBAD);
      end
      idle(2);
      chk("loads_after_gapped", DW'(loads_done), DW'(2));

      // Abort after two words, then a fresh full load
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, words[0]);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, words[1]);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
      idle(2);
      chk("count_after_abort", DW'(count_o), DW'(2));
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, words[i]);
      idle(2);
      chk("loads_after_abort", DW'(loads_done), DW'(3));

      // Reset mid-load, then valid without start
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, words[i]);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, words[3]);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h55);

      // start during LOAD ignored; abort with valid discards the word
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, words[0]);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, words[1]);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, words[2]);
      idle(2);
      chk("loads_after_start_abort", DW'(loads_done), DW'(3));

`ifdef NN_WL_CHECKSUM_EN
      // Checksum wraps modulo 2^32
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h2);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h3);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h4);
      chk("checksum_wrap", checksum_o, 32'h0000_0008);
      idle(2);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic rn, st, ab, vld;
         rn  = ($urandom_range(0, 59) != 0);
         st  = ($urandom_range(0, 3) == 0);
         ab  = ($urandom_range(0, 15) == 0);
         vld = ($urandom_range(0, 9) < 7);
         cycle(rn, st, ab, vld, $urandom);
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
